// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, KILL} fetch_state_t;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] pc_plus4;
    logic valid;
    logic misalign;
  } if_id_t;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: pipeline register with async reset and flush > stall > load > bubble priority.
module if_id_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= BUBBLE;
    else if (flush) q <= BUBBLE;
    else if (!stall) q <= load ? d : BUBBLE;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, single-outstanding imem handshake, hold buffer and IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o,
  output logic            misalign_d_o
);
  localparam int W = 32 + 2*XLEN + 2;
  fetch_state_t state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_out, target;
  logic [31:0] hold_instr;
  logic mis, fresh, accept, deliver, capture;
  logic [W-1:0] d, q;
  assign target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign accept = imem_req_o && imem_ready_i;
  assign imem_addr_o = pc_f;
  always_comb begin
    state_nxt = state;
    imem_req_o = 1'b0;
    deliver = 1'b0;
    capture = 1'b0;
    case (state)
      ISSUE: begin
        imem_req_o = !redirect_i;
        state_nxt = (!redirect_i && imem_ready_i) ? WAIT : ISSUE;
      end
      WAIT:
        if (redirect_i) state_nxt = imem_rvalid_i ? ISSUE : KILL;
        else if (imem_rvalid_i) begin
          deliver = !stall_d_i;
          capture = stall_d_i;
          imem_req_o = !stall_d_i;
          state_nxt = stall_d_i ? HOLD : imem_ready_i ? WAIT : ISSUE;
        end
      HOLD:
        if (redirect_i) state_nxt = ISSUE;
        else if (!stall_d_i) begin
          deliver = 1'b1;
          state_nxt = ISSUE;
        end
      KILL: state_nxt = imem_rvalid_i ? ISSUE : KILL;
      default: state_nxt = ISSUE;
    endcase
  end
  // fresh masks the response of a request that was in flight when reset hit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ISSUE;
      pc_f <= RESET_PC;
      pc_out <= '0;
      hold_instr <= '0;
      mis <= 1'b0;
      fresh <= 1'b1;
    end else begin
      state <= state_nxt;
      fresh <= 1'b0;
      pc_f <= redirect_i ? target : accept ? pc_f + XLEN'(4) : pc_f;
      if (accept) pc_out <= pc_f;
      if (capture) hold_instr <= imem_rdata_i;
      mis <= redirect_i ? |redirect_pc_i[1:0] : deliver ? 1'b0 : mis;
    end
  assign d = {state == HOLD ? hold_instr : imem_rdata_i, pc_out, pc_out + XLEN'(4), 1'b1, mis};
  if_id_reg #(
    .W(W),
    .BUBBLE({NOP_INSTR, {(2*XLEN+2){1'b0}}})
  ) u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(flush_d_i),
    .stall(stall_d_i),
    .load(deliver),
    .d(d),
    .q(q)
  );
  assign {instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, misalign_d_o} = q;
  assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid_i && !fresh && (state == ISSUE || state == HOLD)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, latency-programmable imem and stream-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst = 1;
  logic redirect_i = 0, stall_d_i = 0, flush_d_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic imem_req_o, imem_ready_i = 1, imem_rvalid_i = 0;
  logic [31:0] imem_addr_o, imem_rdata_i = 0;
  logic [31:0] instr_d_o, pc_d_o, pc_plus4_d_o;
  logic valid_d_o, misalign_d_o;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1;
  logic stale_req = 0;
  logic [31:0] q_addr[$];
  int q_due[$];
  logic [31:0] exp_fetch, exp_pc, p_instr, p_pc, p_pc4;
  logic exp_mis, prev_rst = 1, prev_flush = 0, prev_stall = 0, p_valid, p_mis;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .instr_d_o(instr_d_o), .pc_d_o(pc_d_o),
    .pc_plus4_d_o(pc_plus4_d_o), .valid_d_o(valid_d_o), .misalign_d_o(misalign_d_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // instruction memory: one response per accepted request, lat cycles later
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      imem_rvalid_i = stale_req;
      imem_rdata_i = stale_req ? 32'hDEAD_BEEF : 32'hBAD0_0000;
    end else if (q_due.size() > 0 && q_due[0] == cyc) begin
      imem_rvalid_i = 1;
      imem_rdata_i = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid_i = 0;
      imem_rdata_i = 32'hBAD0_0000;
    end
  end

  // reference model: fetch addresses and delivered instructions form sequential streams
  // restarted by redirects; IF/ID obeys flush/stall/bubble rules
  always @(negedge clk) begin
    if (rst) begin
      exp_fetch = RESET_PC;
      exp_pc = RESET_PC;
      exp_mis = 0;
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("rst_instr", instr_d_o, NOP);
        chk("rst_pc", pc_d_o, 0);
        chk("rst_pc4", pc_plus4_d_o, 0);
        chk("rst_valid", 32'(valid_d_o), 0);
        chk("rst_mis", 32'(misalign_d_o), 0);
      end else if (prev_flush) begin
        chk("flush_valid", 32'(valid_d_o), 0);
        chk("flush_instr", instr_d_o, NOP);
        chk("flush_mis", 32'(misalign_d_o), 0);
      end else if (prev_stall) begin
        chk("stall_instr", instr_d_o, p_instr);
        chk("stall_pc", pc_d_o, p_pc);
        chk("stall_pc4", pc_plus4_d_o, p_pc4);
        chk("stall_valid", 32'(valid_d_o), 32'(p_valid));
        chk("stall_mis", 32'(misalign_d_o), 32'(p_mis));
      end else if (valid_d_o) begin
        chk("deliver_pc", pc_d_o, exp_pc);
        chk("deliver_instr", instr_d_o, mem_word(exp_pc));
        chk("deliver_pc4", pc_plus4_d_o, exp_pc + 4);
        chk("deliver_mis", 32'(misalign_d_o), 32'(exp_mis));
        exp_pc = exp_pc + 4;
        exp_mis = 0;
      end else begin
        chk("bubble_instr", instr_d_o, NOP);
        chk("bubble_mis", 32'(misalign_d_o), 0);
      end
      if (redirect_i) chk("req_on_redirect", 32'(imem_req_o), 0);
      if (imem_req_o && imem_ready_i) begin
        chk("fetch_addr", imem_addr_o, exp_fetch);
        chk("one_outstanding", 32'(q_addr.size()), 0);
        exp_fetch = exp_fetch + 4;
        q_addr.push_back(imem_addr_o);
        q_due.push_back(cyc + lat);
      end
      if (redirect_i) begin
        exp_fetch = {redirect_pc_i[31:2], 2'b00};
        exp_pc = exp_fetch;
        exp_mis = |redirect_pc_i[1:0];
      end
      prev_rst = 0;
    end
    prev_flush = flush_d_i;
    prev_stall = stall_d_i;
    p_instr = instr_d_o;
    p_pc = pc_d_o;
    p_pc4 = pc_plus4_d_o;
    p_valid = valid_d_o;
    p_mis = misalign_d_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    // latency 1 streaming
    repeat (3) step();
    rst = 0;
    neg(1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    chk("t1_req0", 32'(imem_req_o), 1);
    chk("t1_valid0", 32'(valid_d_o), 0);
    neg(1);
    chk("t1_addr1", imem_addr_o, 32'h4);
    neg(1);
    chk("t1_pc_c2", pc_d_o, 32'h0);
    chk("t1_valid_c2", 32'(valid_d_o), 1);
    chk("t1_instr_c2", instr_d_o, 32'h5A00_0000);
    chk("t1_addr2", imem_addr_o, 32'h8);
    neg(1);
    chk("t1_pc_c3", pc_d_o, 32'h4);
    chk("t1_pc4_c3", pc_plus4_d_o, 32'h8);
    // redirect quiesces the memory, then latency 3
    step();
    redirect_i = 1; flush_d_i = 1; redirect_pc_i = 32'h40; lat = 3;
    step();
    redirect_i = 0; flush_d_i = 0;
    neg(1);
    chk("t2_addr", imem_addr_o, 32'h40);
    chk("t2_req", 32'(imem_req_o), 1);
    neg(4);
    chk("t2_pc", pc_d_o, 32'h40);
    chk("t2_valid", 32'(valid_d_o), 1);
    chk("t2_instr", instr_d_o, 32'h5A00_0040);
    neg(1);
    chk("t2_bubble_valid", 32'(valid_d_o), 0);
    chk("t2_bubble_instr", instr_d_o, NOP);
    // stall for 4 cycles across a response
    step();
    step();
    stall_d_i = 1;
    neg(1);
    chk("t3_pc_before", pc_d_o, 32'h44);
    step();
    step();
    neg(1);
    chk("t3_req_stalled_rsp", 32'(imem_req_o), 0);
    step();
    neg(1);
    chk("t3_frozen_pc", pc_d_o, 32'h44);
    chk("t3_frozen_valid", 32'(valid_d_o), 1);
    chk("t3_req_hold", 32'(imem_req_o), 0);
    step();
    stall_d_i = 0;
    neg(1);
    chk("t3_req_release", 32'(imem_req_o), 0);
    step();
    neg(1);
    chk("t3_held_pc", pc_d_o, 32'h48);
    chk("t3_held_valid", 32'(valid_d_o), 1);
    chk("t3_next_addr", imem_addr_o, 32'h4C);
    neg(1);
    chk("t3_after_valid", 32'(valid_d_o), 0);
    // redirect in WAIT: stale response discarded
    step();
    redirect_i = 1; flush_d_i = 1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 0; flush_d_i = 0;
    neg(1);
    chk("t4_req_kill", 32'(imem_req_o), 0);
    neg(1);
    chk("t4_addr", imem_addr_o, 32'h100);
    neg(3);
    // misaligned redirect with flush (and stall, which flush overrides)
    step();
    redirect_i = 1; flush_d_i = 1; stall_d_i = 1; redirect_pc_i = 32'h102;
    neg(1);
    chk("t4_pc", pc_d_o, 32'h100);
    chk("t4_valid", 32'(valid_d_o), 1);
    step();
    redirect_i = 0; flush_d_i = 0; stall_d_i = 0;
    neg(1);
    chk("t5_flush_valid", 32'(valid_d_o), 0);
    chk("t5_flush_instr", instr_d_o, NOP);
    neg(2);
    chk("t5_addr", imem_addr_o, 32'h100);
    neg(4);
    chk("t5_pc", pc_d_o, 32'h100);
    chk("t5_mis", 32'(misalign_d_o), 1);
    chk("t5_valid", 32'(valid_d_o), 1);
    neg(3);
    chk("t5_pc_next", pc_d_o, 32'h104);
    chk("t5_mis_next", 32'(misalign_d_o), 0);
    // mixed ready back-pressure and stalls, checked by the model
    for (int i = 0; i < 30; i++) begin
      step();
      imem_ready_i = (i % 3 != 1);
      stall_d_i = (i % 5 == 2) || (i % 7 == 3);
    end
    step();
    imem_ready_i = 1; stall_d_i = 0;
    // reset while a request is outstanding
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      neg(1);
      seen = imem_req_o && imem_ready_i;
    end
    chk("t6_found_accept", 32'(seen), 1);
    step();
    rst = 1;
    step();
    stale_req = 1;
    step();
    rst = 0; stale_req = 0;
    neg(1);
    chk("t6_rst_addr", imem_addr_o, RESET_PC);
    chk("t6_rst_req", 32'(imem_req_o), 1);
    chk("t6_rst_valid", 32'(valid_d_o), 0);
    chk("t6_rst_instr", instr_d_o, NOP);
    neg(4);
    chk("t6_first_pc", pc_d_o, RESET_PC);
    chk("t6_first_instr", instr_d_o, mem_word(RESET_PC));
    chk("t6_first_valid", 32'(valid_d_o), 1);
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
